// File: rtl/fpu_wb_trace_pkg.sv
// Shared types, default widths and helpers for the FP writeback trace block.
package fpu_wb_trace_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_CNT_W = 16;
  localparam int WN_W      = 5;
  localparam int WD_W      = 32;

  // Writeback payload; a FIFO entry is this record followed by the TS_W-bit stamp,
  // i.e. {wn, wd, ts}, so the stamp width can follow the top-level parameter.
  typedef struct packed {
    logic [WN_W-1:0] wn;
    logic [WD_W-1:0] wd;
  } wb_t;

  // Entry record at the default stamp width.
  typedef struct packed {
    wb_t                 wb;
    logic [DEF_TS_W-1:0] ts;
  } entry_t;

  // Saturating increment of a w-bit value (w <= 32) carried in a 32-bit container.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/fpu_wb_trace_fifo.sv
// Generic show-ahead synchronous FIFO with explicit occupancy counter.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  // Accept/advance decisions; a push into a full FIFO is allowed only alongside a pop.
  always_comb begin
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (do_push & ~flush & ~clr) mem_q[wr_ptr_q] <= din;
  end

  // Show-ahead read port.
  always_comb begin
    dout  = mem_q[rd_ptr_q];
    level = level_q;
  end

endmodule

// File: rtl/fpu_wb_trace.sv
// FP register-file writeback tracer: stamps each write, buffers it, counts stalls and drops.
module fpu_wb_trace
  import fpu_wb_trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TS_W  = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     ww,
  input  logic [4:0]               wn,
  input  logic [31:0]              wd,
  input  logic                     stl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_wn,
  output logic [31:0]              out_wd,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int EW = $bits(wb_t) + TS_W;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             push_req, pop, full, empty;
  logic [EW-1:0]    din, dout;
  wb_t              head_wb;

  // Push gating, drop detection and next-state of stamp and counters.
  always_comb begin
    push_req = en & ww;
    pop      = ~empty & out_ready;
    din      = {wn, wd, ts_q};
    ts_d     = ts_q + TS_W'(1);
    drop_d   = drop_q;
    stall_d  = stall_q;
    // A flushed push is simply lost, not a drop.
    if (push_req & full & ~pop & ~flush) drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
    if (stl) stall_d = CNT_W'(sat_inc(32'(stall_q), CNT_W));
  end

  // Free-running stamp and saturating event counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      ts_q    <= '0;
      drop_q  <= '0;
      stall_q <= '0;
    end else begin
      ts_q    <= ts_d;
      drop_q  <= drop_d;
      stall_q <= stall_d;
    end
  end

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .push  (push_req),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Unpack the head entry onto the reader interface.
  always_comb begin
    {head_wb, out_ts} = dout;
    out_wn    = head_wb.wn;
    out_wd    = head_wb.wd;
    out_valid = ~empty;
    drop_cnt  = drop_q;
    stall_cnt = stall_q;
  end

endmodule

// File: doc/fpu_wb_trace.md
# fpu_wb_trace

Writeback trace capture for the FPU/IU pipeline. Every cycle in which the FP register file is written (`ww` high), the block samples the write port (`wn`, `wd`) with a free-running cycle stamp. It buffers the sample in a FIFO and presents it to a downstream reader through a valid/ready handshake. It sits beside `fpu_1_iu`, tapping its `wn`/`wd`/`ww`/`stl` outputs, and feeds a trace sink or self-checking bench. It also counts stall cycles and dropped writebacks.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `TS_W`, 16: cycle-stamp width.
- `CNT_W`, 16: width of the stall and drop counters.
- `clk` in 1: rising-edge clock; same clock as the CPU.
- `clr` in 1: reset, synchronous, active-high.
- `en` in 1: capture enable; when low, writebacks are ignored and not counted as drops.
- `flush` in 1: synchronous FIFO clear.
- `ww` in 1: FP register write strobe.
- `wn` in 5: FP destination register number.
- `wd` in 32: FP writeback data.
- `stl` in 1: pipeline stall indicator.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: reader accepts the head entry.
- `out_wn` out 5: head entry register number.
- `out_wd` out 32: head entry data.
- `out_ts` out TS_W: head entry cycle stamp.
- `level` out log2(DEPTH)+1: current occupancy.
- `drop_cnt` out CNT_W: writebacks lost because the FIFO was full; saturating.
- `stall_cnt` out CNT_W: cycles with `stl` high; saturating.

## Operation
- **Cycle stamp.** `ts` is TS_W bits, free-running, and increments every cycle. It wraps from all-ones to 0.
- **Push.** A push is requested when `en & ww`. The captured entry is {`wn`, `wd`, `ts` of the same cycle}.
- **Pop.** A pop occurs when `out_valid & out_ready`.
- **Read side.** The FIFO is show-ahead: `out_*` always reflect the entry at the read pointer. `out_valid` is `level != 0`.
- **Full.** When `level == DEPTH`:
  - Push without pop: the entry is discarded and `drop_cnt` increments, saturating at all-ones.
  - Push together with pop: the push is accepted and `level` is unchanged.
- **Empty.** When `level == 0`, a push is accepted. A pop is impossible because `out_valid` is 0, so `out_ready` is ignored.
- **Simultaneous push and pop, non-empty and non-full:** both happen and `level` is unchanged.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `level` is maintained as an explicit counter.
- **Flush.**
  - Sets pointers and `level` to 0 and takes priority over a push or pop in the same cycle; the push in that cycle is lost and is not counted as a drop.
  - `ts`, `drop_cnt` and `stall_cnt` are unaffected.
- **Stall counter.** `stall_cnt` increments in every cycle with `stl` high, saturating at all-ones. `en` does not gate it.
- **Reset.** `clr` overrides everything. It zeroes `ts`, the pointers, `level`, `drop_cnt` and `stall_cnt`.
  - A capture in progress during reset is lost.
  - FIFO storage contents are not reset.
- **Reset values of outputs:** `out_valid`=0, `level`=0, `drop_cnt`=0, `stall_cnt`=0. `out_wn`/`out_wd`/`out_ts` are don't-care while `out_valid`=0.

## Timing
- All state updates on the rising edge of `clk`.
- **Latency.** A push sampled at edge N is visible on `out_*` with `out_valid`=1 after edge N, i.e. during cycle N+1. There is no bypass from `ww` to `out_*` in the same cycle.
- **Pop.** A pop at edge N advances the head during cycle N+1.
- **Throughput.** Sustained one push and one pop per cycle.
- **Counters.** `drop_cnt` and `stall_cnt` reflect the event one cycle after it is sampled.
- **First cycle after reset.** `ts`=0 in the first cycle after `clr` deasserts, so the first stamp captured is 0.

## Structure
- Shared package: the entry record typedef {`wn`[4:0], `wd`[31:0], `ts`[TS_W-1:0]}, the default widths, and the `sat_inc` helper function.
- One sub-module: `trace_fifo`, a generic show-ahead synchronous FIFO with `push`, `pop`, `flush`, `level` and `full`/`empty`, parameterised by width and depth.
- The top level adds the stamp counter, push gating, drop logic and stall counter.

## Test plan
1. **Basic capture.** Reset, then `ww`=1, `wn`=3, `wd`=0x3F800000 in the first cycle after reset, with `out_ready`=0. Next cycle: `out_valid`=1, `out_wn`=3, `out_wd`=0x3F800000, `out_ts`=0, `level`=1.
2. **Fill to full and drop.** `DEPTH`=16, `out_ready`=0, `ww` held for 18 cycles. Required: `level`=16, `drop_cnt`=2, and the head `out_ts` is the first push's stamp.
3. **Full with simultaneous pop.** Full FIFO, `ww`=1 and `out_ready`=1 for 5 cycles. Required: `level` stays 16, `drop_cnt` unchanged, 5 entries are read out in stamp order.
4. **Wrap-around.** 40 writebacks with `wd`=i, popped at a rate of one every other cycle with `DEPTH`=16 and no drops. Required: the reader sees `wd` 0..39 in order and the pointers wrap twice.
5. **Stamp wrap, stall saturation and flush.** Run with `TS_W`=4 and `CNT_W`=4:
   - Capture at cycle 17 gives `out_ts`=1.
   - `stl` high for 20 cycles gives `stall_cnt`=15.
   - `flush` with `ww`=1 in the same cycle gives `level`=0 and `drop_cnt` unchanged.
6. **Reset mid-operation and capture gating.** `level`=5 when `clr` is pulsed. Required: next cycle `out_valid`=0, `level`=0, `drop_cnt`=0, and `ts` restarts at 0. A subsequent `ww` with `en`=0 leaves `level`=0.
